bcd_step_counter: RTL

Prescaled single-digit BCD counter that produces the 4-bit digit consumed by the BCD-to-7-segment decoder stage. The digit bits come out as A (MSB) through D (LSB), so they wire straight onto the decoder's A/B/C/D inputs. The block also has a synchronous load, a count enable and a carry pulse, so several instances can be cascaded into multi-digit displays.

---
 rtl/bcd_step_counter.sv | 96 +++++++++
 1 files changed

// File: rtl/bcd_step_counter.sv
// Prescaled single-digit BCD counter with load, enable, tick and carry for cascading.
// Define BCD_DOWN_EN to add the dir port and down-counting (carry then also marks 0->9 borrows).
module bcd_step_counter #(
  parameter int unsigned PRESCALE = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_val,
`ifdef BCD_DOWN_EN
  input  logic       dir,
`endif
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       tick,
  output logic       carry
);

  localparam int unsigned PcntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PcntW-1:0] PcntMax = PcntW'(PRESCALE - 1);

  logic [PcntW-1:0] pcnt_q, pcnt_d;
  logic [3:0]       dig_q, dig_d;
  logic             tick_q, tick_d;
  logic             carry_q, carry_d;

  logic [3:0]       dig_step;
  logic             dig_wrap;

  // Value the digit would take on a step, and whether that step wraps.
  always_comb begin
    dig_step = dig_q + 4'd1;
    dig_wrap = 1'b0;
`ifdef BCD_DOWN_EN
    if (dir) begin
      if (dig_q == 4'd0 || dig_q > 4'd9) begin
        dig_step = 4'd9;
        dig_wrap = (dig_q == 4'd0);
      end else begin
        dig_step = dig_q - 4'd1;
      end
    end else if (dig_q >= 4'd9) begin
      dig_step = 4'd0;
      dig_wrap = 1'b1;
    end
`else
    if (dig_q >= 4'd9) begin
      dig_step = 4'd0;
      dig_wrap = 1'b1;
    end
`endif
  end

  always_comb begin
    pcnt_d  = pcnt_q;
    dig_d   = dig_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    if (load) begin
      // Non-BCD load values are replaced by zero so the digit never leaves 0..9.
      dig_d  = (load_val <= 4'd9) ? load_val : 4'd0;
      pcnt_d = '0;
    end else if (en) begin
      if (pcnt_q == PcntMax) begin
        pcnt_d  = '0;
        tick_d  = 1'b1;
        dig_d   = dig_step;
        carry_d = dig_wrap;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q  <= '0;
      dig_q   <= 4'd0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      dig_q   <= dig_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end

  assign {A, B, C, D} = dig_q;
  assign tick         = tick_q;
  assign carry        = carry_q;

endmodule
